// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin arbiter for a pipelined Wishbone bus in front of a shared SDRAM controller.
// State | meaning: IDLE | no owner, arbitrate; GNT0 | m0 owns the bus; GNT1 | m1 owns the bus
module wb_rr_arbiter #(
  parameter int ADDR_BITS       = 8,
  parameter int BYTES           = 1,
  parameter int SEL_WIDTH       = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [ADDR_BITS-1:0] m0_wb_addr,
  input  logic [BYTES*8-1:0]   m0_wb_dat_m2s,
  input  logic                 m0_wb_we,
  input  logic [SEL_WIDTH-1:0] m0_wb_sel,
  input  logic                 m0_wb_stb,
  input  logic                 m0_wb_cyc,
  output logic [BYTES*8-1:0]   m0_wb_dat_s2m,
  output logic                 m0_wb_ack,
  output logic                 m0_wb_stall,
  input  logic [ADDR_BITS-1:0] m1_wb_addr,
  input  logic [BYTES*8-1:0]   m1_wb_dat_m2s,
  input  logic                 m1_wb_we,
  input  logic [SEL_WIDTH-1:0] m1_wb_sel,
  input  logic                 m1_wb_stb,
  input  logic                 m1_wb_cyc,
  output logic [BYTES*8-1:0]   m1_wb_dat_s2m,
  output logic                 m1_wb_ack,
  output logic                 m1_wb_stall,
  output logic [ADDR_BITS-1:0] s_wb_addr,
  output logic [BYTES*8-1:0]   s_wb_dat_m2s,
  output logic                 s_wb_we,
  output logic [SEL_WIDTH-1:0] s_wb_sel,
  output logic                 s_wb_stb,
  output logic                 s_wb_cyc,
  input  logic [BYTES*8-1:0]   s_wb_dat_s2m,
  input  logic                 s_wb_ack,
  input  logic                 s_wb_stall,
  output logic [1:0]           grant
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last_grant, last_grant_nxt;  // 1 = m1 was the last owner
  logic [CW-1:0] count, count_nxt;
  logic          full;
  logic          accept;
  logic          ack_dec;

  assign full    = (count == CW'(MAX_OUTSTANDING));
  assign accept  = s_wb_stb && !s_wb_stall;
  assign ack_dec = s_wb_ack && (count != '0);

  assign m0_wb_dat_s2m = s_wb_dat_s2m;
  assign m1_wb_dat_s2m = s_wb_dat_s2m;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    count_nxt      = count;
    case (state)
      IDLE: begin
        count_nxt = '0;
        if (m0_wb_cyc && m1_wb_cyc) state_nxt = last_grant ? GNT0 : GNT1;
        else if (m0_wb_cyc)         state_nxt = GNT0;
        else if (m1_wb_cyc)         state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        // Dropping cyc ends the cycle; any outstanding requests are abandoned.
        if ((state == GNT0) ? !m0_wb_cyc : !m1_wb_cyc) begin
          state_nxt      = IDLE;
          count_nxt      = '0;
          last_grant_nxt = (state == GNT1);
        end else if (accept && !ack_dec) begin
          count_nxt = count + CW'(1);
        end else if (!accept && ack_dec) begin
          count_nxt = count - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_wb_addr    = '0;
    s_wb_dat_m2s = '0;
    s_wb_we      = 1'b0;
    s_wb_sel     = '0;
    s_wb_stb     = 1'b0;
    s_wb_cyc     = 1'b0;
    m0_wb_stall  = 1'b1;
    m1_wb_stall  = 1'b1;
    m0_wb_ack    = 1'b0;
    m1_wb_ack    = 1'b0;
    grant        = 2'b00;
    case (state)
      GNT0: begin
        grant        = 2'b01;
        s_wb_addr    = m0_wb_addr;
        s_wb_dat_m2s = m0_wb_dat_m2s;
        s_wb_we      = m0_wb_we;
        s_wb_sel     = m0_wb_sel;
        s_wb_stb     = m0_wb_stb && !full;
        s_wb_cyc     = m0_wb_cyc;
        m0_wb_stall  = s_wb_stall || full;
        m0_wb_ack    = s_wb_ack;
      end
      GNT1: begin
        grant        = 2'b10;
        s_wb_addr    = m1_wb_addr;
        s_wb_dat_m2s = m1_wb_dat_m2s;
        s_wb_we      = m1_wb_we;
        s_wb_sel     = m1_wb_sel;
        s_wb_stb     = m1_wb_stb && !full;
        s_wb_cyc     = m1_wb_cyc;
        m1_wb_stall  = s_wb_stall || full;
        m1_wb_ack    = s_wb_ack;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: request scoreboard on the slave side plus
// grant/stall/ack checks at each step.
module tb_wb_rr_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic [AW-1:0] m0_wb_addr = '0, m1_wb_addr = '0;
  logic [DW-1:0] m0_wb_dat_m2s = '0, m1_wb_dat_m2s = '0;
  logic          m0_wb_we = 0, m1_wb_we = 0;
  logic [0:0]    m0_wb_sel = '0, m1_wb_sel = '0;
  logic          m0_wb_stb = 0, m1_wb_stb = 0, m0_wb_cyc = 0, m1_wb_cyc = 0;
  logic [DW-1:0] m0_wb_dat_s2m, m1_wb_dat_s2m;
  logic          m0_wb_ack, m1_wb_ack, m0_wb_stall, m1_wb_stall;
  logic [AW-1:0] s_wb_addr;
  logic [DW-1:0] s_wb_dat_m2s;
  logic          s_wb_we;
  logic [0:0]    s_wb_sel;
  logic          s_wb_stb, s_wb_cyc;
  logic [DW-1:0] s_wb_dat_s2m = '0;
  logic          s_wb_ack = 0, s_wb_stall = 0;
  logic [1:0]    grant;

  wb_rr_arbiter #(.ADDR_BITS(AW), .BYTES(1), .SEL_WIDTH(1), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .areset(areset),
    .m0_wb_addr(m0_wb_addr), .m0_wb_dat_m2s(m0_wb_dat_m2s), .m0_wb_we(m0_wb_we),
    .m0_wb_sel(m0_wb_sel), .m0_wb_stb(m0_wb_stb), .m0_wb_cyc(m0_wb_cyc),
    .m0_wb_dat_s2m(m0_wb_dat_s2m), .m0_wb_ack(m0_wb_ack), .m0_wb_stall(m0_wb_stall),
    .m1_wb_addr(m1_wb_addr), .m1_wb_dat_m2s(m1_wb_dat_m2s), .m1_wb_we(m1_wb_we),
    .m1_wb_sel(m1_wb_sel), .m1_wb_stb(m1_wb_stb), .m1_wb_cyc(m1_wb_cyc),
    .m1_wb_dat_s2m(m1_wb_dat_s2m), .m1_wb_ack(m1_wb_ack), .m1_wb_stall(m1_wb_stall),
    .s_wb_addr(s_wb_addr), .s_wb_dat_m2s(s_wb_dat_m2s), .s_wb_we(s_wb_we),
    .s_wb_sel(s_wb_sel), .s_wb_stb(s_wb_stb), .s_wb_cyc(s_wb_cyc),
    .s_wb_dat_s2m(s_wb_dat_s2m), .s_wb_ack(s_wb_ack), .s_wb_stall(s_wb_stall),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every request the slave accepts must be the oldest one a master presented.
  task automatic mon();
    logic [31:0] e;
    if (s_wb_stb && !s_wb_stall) begin
      n_acc++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_req", {14'b0, s_wb_we, s_wb_sel, s_wb_addr, s_wb_dat_m2s}, e);
      end
    end
  endtask

  task automatic settle();
    #1;
    mon();
  endtask

  task automatic present(input int m, input logic [7:0] a);
    exp_q.push_back({14'b0, 1'b1, 1'b1, a, ~a});
    if (m == 0) begin
      m0_wb_stb = 1; m0_wb_addr = a; m0_wb_dat_m2s = ~a; m0_wb_we = 1; m0_wb_sel = 1'b1;
    end else begin
      m1_wb_stb = 1; m1_wb_addr = a; m1_wb_dat_m2s = ~a; m1_wb_we = 1; m1_wb_sel = 1'b1;
    end
  endtask

  task automatic set_cyc(input int m, input logic v);
    if (m == 0) begin m0_wb_cyc = v; if (!v) m0_wb_stb = 0; end
    else begin m1_wb_cyc = v; if (!v) m1_wb_stb = 0; end
  endtask

  function automatic logic stall_of(input int m);
    return (m == 0) ? m0_wb_stall : m1_wb_stall;
  endfunction

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_wb_ack : m1_wb_ack;
  endfunction

  // Master m (already granted) streams requests until it is stalled; n = number accepted.
  task automatic run_until_stall(input int m, input logic [7:0] base, input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      s_wb_ack = 0;
      present(m, base + 8'(n));
      settle();
      chk("other_stall", 32'(stall_of(1 - m)), 1);
      chk("other_ack", 32'(ack_of(1 - m)), 0);
      if (stall_of(m)) break;
      n++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1;
    set_cyc(0, 0); set_cyc(1, 0); s_wb_ack = 0; s_wb_stall = 0;
    exp_q.delete();
    @(negedge clk);
    areset = 0;
  endtask

  initial begin
    int n;
    int acc0;

    // Reset holds outputs quiet even with live master/slave inputs.
    m0_wb_cyc = 1; m0_wb_stb = 1; s_wb_ack = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_scyc", s_wb_cyc, 0);
    chk("rst_sstb", s_wb_stb, 0);
    chk("rst_m0_stall", m0_wb_stall, 1);
    chk("rst_m1_stall", m1_wb_stall, 1);
    chk("rst_m0_ack", m0_wb_ack, 0);
    chk("rst_m1_ack", m1_wb_ack, 0);
    do_reset();

    // m0 alone: three writes, acks two cycles after acceptance.
    acc0 = n_acc;
    @(negedge clk); set_cyc(0, 1); present(0, 8'h10); settle();
    chk("s1_idle_grant", grant, 0);
    chk("s1_idle_stall", m0_wb_stall, 1);
    chk("s1_idle_scyc", s_wb_cyc, 0);
    @(negedge clk); settle();
    chk("s1_grant", grant, 2'b01);
    chk("s1_scyc", s_wb_cyc, 1);
    @(negedge clk); present(0, 8'h11); settle();
    @(negedge clk); present(0, 8'h12); s_wb_ack = 1; settle();
    chk("s1_ack_a", m0_wb_ack, 1);
    @(negedge clk); m0_wb_stb = 0; settle();
    chk("s1_ack_b", m0_wb_ack, 1);
    @(negedge clk); settle();
    chk("s1_ack_c", m0_wb_ack, 1);
    @(negedge clk); s_wb_ack = 0; set_cyc(0, 0); settle();
    chk("s1_hold", grant, 2'b01);
    @(negedge clk); settle();
    chk("s1_idle_end", grant, 0);
    chk("s1_stb_pulses", 32'(n_acc - acc0), 3);

    // Tie after reset: m0 first, one IDLE gap, then m1; next tie to m0.
    do_reset();
    @(negedge clk); set_cyc(0, 1); set_cyc(1, 1); settle();
    chk("s2_idle", grant, 0);
    @(negedge clk); present(0, 8'h20); settle();
    chk("s2_tie1", grant, 2'b01);
    chk("s2_m1_stall", m1_wb_stall, 1);
    @(negedge clk); m0_wb_stb = 0; s_wb_ack = 1; s_wb_dat_s2m = 8'h5A; settle();
    chk("s2_m0_ack", m0_wb_ack, 1);
    chk("s2_m1_ack", m1_wb_ack, 0);
    chk("s2_dat0", m0_wb_dat_s2m, 8'h5A);
    chk("s2_dat1", m1_wb_dat_s2m, 8'h5A);
    @(negedge clk); s_wb_ack = 0; set_cyc(0, 0); settle();
    chk("s2_hold", grant, 2'b01);
    @(negedge clk); settle();
    chk("s2_gap", grant, 0);
    @(negedge clk); present(1, 8'h30); settle();
    chk("s2_m1_grant", grant, 2'b10);
    chk("s2_m0_stall", m0_wb_stall, 1);
    @(negedge clk); m1_wb_stb = 0; s_wb_ack = 1; settle();
    chk("s2_m1_ack2", m1_wb_ack, 1);
    chk("s2_m0_ack2", m0_wb_ack, 0);
    @(negedge clk); s_wb_ack = 0; set_cyc(1, 0); settle();
    @(negedge clk); set_cyc(0, 1); set_cyc(1, 1); settle();
    chk("s2_idle2", grant, 0);
    @(negedge clk); settle();
    chk("s2_tie2", grant, 2'b01);
    @(negedge clk); set_cyc(0, 0); set_cyc(1, 0); settle();
    @(negedge clk); settle();
    chk("s2_idle3", grant, 0);

    // Outstanding limit: slave never acks, only four get through.
    acc0 = n_acc;
    @(negedge clk); set_cyc(0, 1); settle();
    run_until_stall(0, 8'h40, 8, n);
    chk("s3_accepted", n, 4);
    @(negedge clk); settle();
    chk("s3_stall", m0_wb_stall, 1);
    chk("s3_sstb", s_wb_stb, 0);
    @(negedge clk); s_wb_ack = 1; settle();
    chk("s3_ack", m0_wb_ack, 1);
    chk("s3_stall_ack", m0_wb_stall, 1);
    @(negedge clk); s_wb_ack = 0; settle();
    chk("s3_fifth_stall", m0_wb_stall, 0);
    chk("s3_fifth", 32'(n_acc - acc0), 5);
    @(negedge clk); set_cyc(0, 0); settle();
    chk("s3_abort_scyc", s_wb_cyc, 0);
    @(negedge clk); settle();
    chk("s3_idle", grant, 0);

    // Accept and ack together at count 2 while m1 waits with cyc high.
    @(negedge clk); set_cyc(0, 1); settle();
    @(negedge clk); set_cyc(1, 1); present(0, 8'h50); settle();
    chk("s4_grant", grant, 2'b01);
    chk("s4_m1_stall_a", m1_wb_stall, 1);
    @(negedge clk); present(0, 8'h51); settle();
    chk("s4_m1_ack_a", m1_wb_ack, 0);
    @(negedge clk); present(0, 8'h52); s_wb_ack = 1; settle();
    chk("s4_both_stall", m0_wb_stall, 0);
    chk("s4_m0_ack", m0_wb_ack, 1);
    chk("s4_m1_ack_b", m1_wb_ack, 0);
    chk("s4_m1_stall_b", m1_wb_stall, 1);
    run_until_stall(0, 8'h53, 8, n);
    chk("s4_count_held", n, 2);
    @(negedge clk); set_cyc(0, 0); exp_q.delete(); settle();
    chk("s4_abort_scyc", s_wb_cyc, 0);

    // m1 aborts with three outstanding; late ack is not forwarded.
    @(negedge clk); settle();
    chk("s5_idle", grant, 0);
    @(negedge clk); present(1, 8'h60); settle();
    chk("s5_grant", grant, 2'b10);
    @(negedge clk); present(1, 8'h61); settle();
    @(negedge clk); present(1, 8'h62); settle();
    @(negedge clk); set_cyc(1, 0); settle();
    chk("s5_scyc_drop", s_wb_cyc, 0);
    chk("s5_grant_hold", grant, 2'b10);
    @(negedge clk); s_wb_ack = 1; settle();
    chk("s5_idle2", grant, 0);
    chk("s5_late_ack", m1_wb_ack, 0);
    @(negedge clk); s_wb_ack = 0; set_cyc(0, 1); settle();
    run_until_stall(0, 8'h70, 8, n);
    chk("s5_count_cleared", n, 4);

    // Asynchronous reset mid-burst, checked before the next rising edge.
    @(negedge clk); s_wb_ack = 1;
    #2 areset = 1;
    #1;
    chk("s6_grant", grant, 0);
    chk("s6_scyc", s_wb_cyc, 0);
    chk("s6_sstb", s_wb_stb, 0);
    chk("s6_m0_stall", m0_wb_stall, 1);
    chk("s6_m1_stall", m1_wb_stall, 1);
    chk("s6_m0_ack", m0_wb_ack, 0);
    chk("s6_m1_ack", m1_wb_ack, 0);
    @(negedge clk); set_cyc(0, 0); set_cyc(1, 0); s_wb_ack = 0; exp_q.delete();
    @(negedge clk); areset = 0;
    @(negedge clk); set_cyc(0, 1); present(0, 8'h80); settle();
    chk("s6_idle", grant, 0);
    @(negedge clk); settle();
    chk("s6_regrant", grant, 2'b01);
    @(negedge clk); m0_wb_stb = 0; s_wb_ack = 1; settle();
    chk("s6_ack", m0_wb_ack, 1);
    @(negedge clk); s_wb_ack = 0; set_cyc(0, 0); settle();
    @(negedge clk); settle();
    chk("s6_idle_end", grant, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter.md
WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, meaning Wishbone address width.
REQ-002 SHALL have parameter BYTES, default 1, meaning data width in bytes (data = BYTES*8 bits).
REQ-003 SHALL have parameter SEL_WIDTH, default 1, meaning byte-select width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of accepted-but-unacknowledged requests (range 1..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port areset, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have ports m0_wb_addr and m1_wb_addr, input, ADDR_BITS: master request address.
REQ-008 SHALL have ports m0_wb_dat_m2s and m1_wb_dat_m2s, input, BYTES*8: master write data.
REQ-009 SHALL have ports m0/m1_wb_we (input, 1), m0/m1_wb_sel (input, SEL_WIDTH), m0/m1_wb_stb (input, 1) and m0/m1_wb_cyc (input, 1): master controls.
REQ-010 SHALL have ports m0/m1_wb_dat_s2m (output, BYTES*8), m0/m1_wb_ack (output, 1) and m0/m1_wb_stall (output, 1): master responses.
REQ-011 SHALL have ports s_wb_addr, s_wb_dat_m2s, s_wb_we, s_wb_sel, s_wb_stb and s_wb_cyc as outputs, with widths as for the masters, driving the shared SDRAM controller.
REQ-012 SHALL have ports s_wb_dat_s2m (input, BYTES*8), s_wb_ack (input, 1) and s_wb_stall (input, 1).
REQ-013 SHALL have port grant, output, 2 bits: one-hot owner of the shared bus (00 = idle).

Function
REQ-014 SHALL implement a pipelined-Wishbone, two-master round-robin arbiter with states IDLE, GNT0 and GNT1; grant is 01 in GNT0, 10 in GNT1 and 00 in IDLE.
REQ-015 In IDLE: if exactly one mN_wb_cyc is high, the FSM SHALL enter GNTN on the next edge.
REQ-016 In IDLE with both cyc high, the FSM SHALL grant the master not granted last (last_grant register, reset value 1, so m0 wins the first tie).
REQ-017 In GNTn, the s_wb_* request outputs SHALL combinationally mirror master n; in IDLE, s_wb_cyc and s_wb_stb SHALL be 0 and the other s_wb_* outputs 0.
REQ-018 The granted master's stall SHALL equal s_wb_stall OR (count == MAX_OUTSTANDING), and its ack SHALL equal s_wb_ack.
REQ-019 The non-granted master (and both masters in IDLE) SHALL see stall=1 and ack=0.
REQ-020 When count == MAX_OUTSTANDING, s_wb_stb SHALL be forced to 0.
REQ-021 s_wb_dat_s2m SHALL be broadcast to both mN_wb_dat_s2m.
REQ-022 The outstanding counter SHALL behave as follows:
- +1 on an accepted request (s_wb_stb && !s_wb_stall);
- -1 on s_wb_ack;
- unchanged when both occur in the same cycle;
- never decremented below 0 (an ack at count 0 is ignored).
REQ-023 GNTn SHALL return to IDLE when mN_wb_cyc=0 and count=0, updating last_grant=n.
REQ-024 A GNTn to GNTm transition without passing through IDLE SHALL NOT occur; minimum re-arbitration gap is one IDLE cycle.
REQ-025 Abort: if mN_wb_cyc drops while count>0, s_wb_cyc SHALL drop in the same cycle, the counter SHALL clear, and the FSM SHALL go to IDLE on the next edge; acks arriving afterwards are not forwarded.

Reset
REQ-026 While areset=1, the FSM SHALL be IDLE, count=0 and last_grant=1, effective immediately without waiting for a clock edge.
REQ-027 During reset, outputs SHALL be: grant=00, s_wb_cyc=0, s_wb_stb=0, both stall=1, both ack=0.
REQ-028 areset asserted mid-transfer SHALL abandon all outstanding requests; after release, arbitration restarts from IDLE.

Verification
REQ-029 Scenario: m0 only, 3 writes with s_wb_stall=0 and acks 2 cycles later -> grant=01 one cycle after cyc; 3 s_wb_stb pulses; IDLE once count=0 and cyc=0.
REQ-030 Scenario: m0 and m1 raise cyc together after reset -> m0 served first, then IDLE for 1 cycle, then grant=10; the next tie goes to m0.
REQ-031 Scenario: MAX_OUTSTANDING=4, slave never acks, m0 issues 6 stb -> exactly 4 accepted, m0_wb_stall=1 thereafter; one ack -> a 5th is accepted.
REQ-032 Scenario: simultaneous accept and ack at count=2 -> count stays 2; m1 meanwhile holds cyc and sees stall=1 and ack=0 throughout.
REQ-033 Scenario: m1 drops cyc with count=3 -> s_wb_cyc=0 in the same cycle, count=0, next cycle IDLE, a late s_wb_ack is not seen by m1.
REQ-034 Scenario: areset pulsed asynchronously mid-burst -> outputs take their reset values before the next clk edge; after release, a fresh m0 request is granted normally.
